// File: rtl/fe_pkg.sv
// Shared definitions for the fetch stage: reset/NOP constants and the
// one-hot encoding of the next-PC source selected each cycle.
package fe_pkg;

    localparam logic [31:0] FE_RESET_ADDR = 32'h0000_0000;
    localparam logic [31:0] FE_NOP_INST   = 32'h0000_0033; // add x0,x0,x0

    // One-hot next-PC source, listed in decreasing priority.
    typedef enum logic [5:0] {
        SEL_HALT = 6'b000001,
        SEL_EX   = 6'b000010,
        SEL_HOLD = 6'b000100,
        SEL_JALR = 6'b001000,
        SEL_JAL  = 6'b010000,
        SEL_SEQ  = 6'b100000
    } npc_sel_e;

    // True for the sources that move the PC off the sequential path.
    function automatic logic is_redirect(input npc_sel_e sel);
        return (sel == SEL_EX) || (sel == SEL_JALR) || (sel == SEL_JAL);
    endfunction

endpackage

// File: rtl/fe_npc.sv
// Next-PC selection: priority mux over halt, execute branch, decode hold,
// decode jalr/jal and the sequential PC+4, with the target adders.
module fe_npc
    import fe_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] if_pc,
    input  logic        halt,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    input  logic        hold,
    input  logic        dec_jal,
    input  logic        dec_jalr,
    input  logic [31:0] dec_imm,
    input  logic [31:0] dec_jalr_rs1,
    output npc_sel_e    sel,
    output logic [31:0] npc
);

    logic [31:0] seq_pc;
    logic [31:0] jal_tgt;
    logic [31:0] jalr_sum;
    logic [31:0] jalr_tgt;

    // All adders wrap modulo 2^32; only jalr clears bit 0.
    assign seq_pc   = pc + 32'd4;
    assign jal_tgt  = if_pc + dec_imm;
    assign jalr_sum = dec_jalr_rs1 + dec_imm;
    assign jalr_tgt = {jalr_sum[31:1], 1'b0};

    // Priority select of the next PC source; jalr beats jal when both are seen.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        sel = SEL_SEQ;
        npc = seq_pc;
        if (halt) begin
            sel = SEL_HALT;
            npc = pc;
        end else if (ex_redirect) begin
            sel = SEL_EX;
            npc = ex_target;
        end else if (hold) begin
            sel = SEL_HOLD;
            npc = pc;
        end else if (dec_jalr) begin
            sel = SEL_JALR;
            npc = jalr_tgt;
        end else if (dec_jal) begin
            sel = SEL_JAL;
            npc = jal_tgt;
        end
    end

endmodule

// File: rtl/fe.sv
// Fetch stage: owns the PC, drives the instruction-memory address and
// registers the fetched word, its PC and PC+4 into IF/ID for decode.
module fe
    import fe_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = FE_RESET_ADDR,
    parameter logic [31:0] NOP_INST   = FE_NOP_INST
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [31:0] o_imem_raddr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_hold,
    input  logic        i_halt,
    input  logic        i_dec_jal,
    input  logic        i_dec_jalr,
    input  logic [31:0] i_dec_imm,
    input  logic [31:0] i_dec_jalr_rs1,
    input  logic        i_ex_redirect,
    input  logic [31:0] i_ex_target,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_nxt_pc,
    output logic        o_vld,
    output logic        o_flush,
    output logic        o_misalign
);

    logic [31:0] pc_q;
    logic        halt_q;
    logic        misalign_q;
    npc_sel_e    sel;
    logic [31:0] npc;

    assign o_imem_raddr = pc_q;
    assign o_flush      = i_ex_redirect;

    fe_npc u_npc (
        .pc           (pc_q),
        .if_pc        (o_pc),
        .halt         (halt_q | i_halt),
        .ex_redirect  (i_ex_redirect),
        .ex_target    (i_ex_target),
        .hold         (i_hold),
        .dec_jal      (i_dec_jal),
        .dec_jalr     (i_dec_jalr),
        .dec_imm      (i_dec_imm),
        .dec_jalr_rs1 (i_dec_jalr_rs1),
        .sel          (sel),
        .npc          (npc)
    );

    // Sticky halt: once a break/trap retires, fetch stays frozen until reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            halt_q <= 1'b0;
        end else if (i_halt) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            halt_q <= 1'b1;
        end
    end

    // PC, IF/ID and pending-misalign update, driven by the selected next-PC source.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: every architectural register here is reset; the restart point must be deterministic.
            pc_q       <= RESET_ADDR;
            o_inst     <= NOP_INST;
            o_pc       <= RESET_ADDR;
            o_nxt_pc   <= RESET_ADDR + 32'd4;
            o_vld      <= 1'b0;
            o_misalign <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q <= npc;
            if (is_redirect(sel)) begin
                misalign_q <= npc[1];
            end
            case (sel)
                SEL_HOLD: begin
                    // Decode is stalled: IF/ID keeps its word.
                end
                SEL_SEQ: begin
                    o_inst     <= i_imem_rdata;
                    o_pc       <= pc_q;
                    o_nxt_pc   <= pc_q + 32'd4;
                    o_vld      <= 1'b1;
                    o_misalign <= misalign_q;
                    misalign_q <= 1'b0;
                end
                default: begin
                    // Halt or redirect: the word at pc_q is wrong-path, bubble IF/ID.
                    o_inst     <= NOP_INST;
                    o_vld      <= 1'b0;
                    o_misalign <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fe.sv
// Directed bench for the fetch stage: sequential fetch, hold, jal/jalr,
// execute redirect priority, misaligned target, halt and async reset.
module tb_fe;

    logic        i_clk;
    logic        i_rst;
    logic [31:0] o_imem_raddr;
    logic [31:0] i_imem_rdata;
    logic        i_hold;
    logic        i_halt;
    logic        i_dec_jal;
    logic        i_dec_jalr;
    logic [31:0] i_dec_imm;
    logic [31:0] i_dec_jalr_rs1;
    logic        i_ex_redirect;
    logic [31:0] i_ex_target;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic [31:0] o_nxt_pc;
    logic        o_vld;
    logic        o_flush;
    logic        o_misalign;

    int n_vec;
    int n_bad;

    localparam logic [31:0] NOP = 32'h0000_0033;
    localparam logic [31:0] TAG = 32'hC000_0000;

    fe dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .o_imem_raddr   (o_imem_raddr),
        .i_imem_rdata   (i_imem_rdata),
        .i_hold         (i_hold),
        .i_halt         (i_halt),
        .i_dec_jal      (i_dec_jal),
        .i_dec_jalr     (i_dec_jalr),
        .i_dec_imm      (i_dec_imm),
        .i_dec_jalr_rs1 (i_dec_jalr_rs1),
        .i_ex_redirect  (i_ex_redirect),
        .i_ex_target    (i_ex_target),
        .o_inst         (o_inst),
        .o_pc           (o_pc),
        .o_nxt_pc       (o_nxt_pc),
        .o_vld          (o_vld),
        .o_flush        (o_flush),
        .o_misalign     (o_misalign)
    );

    // Instruction memory returns an address-tagged word.
    assign i_imem_rdata = TAG | o_imem_raddr;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // IF/ID contents of a valid word fetched from addr.
    task automatic check_word(input string tag, input logic [31:0] addr);
        check({tag, ".inst"}, o_inst, TAG | addr);
        check({tag, ".pc"},   o_pc, addr);
        check({tag, ".npc"},  o_nxt_pc, addr + 32'd4);
        check({tag, ".vld"},  {31'd0, o_vld}, 32'd1);
    endtask

    task automatic check_bubble(input string tag, input logic [31:0] pc);
        check({tag, ".pcq"},  o_imem_raddr, pc);
        check({tag, ".inst"}, o_inst, NOP);
        check({tag, ".vld"},  {31'd0, o_vld}, 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        i_rst = 1'b1;
        i_hold = 1'b0;
        i_halt = 1'b0;
        i_dec_jal = 1'b0;
        i_dec_jalr = 1'b0;
        i_dec_imm = '0;
        i_dec_jalr_rs1 = '0;
        i_ex_redirect = 1'b0;
        i_ex_target = '0;

        // Reset state.
        #2;
        check("rst.pcq",  o_imem_raddr, 32'h0);
        check("rst.inst", o_inst, NOP);
        check("rst.pc",   o_pc, 32'h0);
        check("rst.npc",  o_nxt_pc, 32'h4);
        check("rst.vld",  {31'd0, o_vld}, 32'd0);
        check("rst.mis",  {31'd0, o_misalign}, 32'd0);
        #5 i_rst = 1'b0;
        #1 check("rel.vld", {31'd0, o_vld}, 32'd0);

        // Sequential fetch: o_pc 0,4,8.
        step(); check_word("seq0", 32'h0);
        step(); check_word("seq4", 32'h4);
        step(); check_word("seq8", 32'h8);
        step(); check("seq.pcq", o_imem_raddr, 32'h10);

        // Hold two cycles at pc_q=0x10.
        i_hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("hold.pcq", o_imem_raddr, 32'h10);
            check_word("hold", 32'hC);
        end
        i_hold = 1'b0;
        step(); check_word("resume", 32'h10);

        // jal from o_pc=0x10, imm=0x18 -> 0x28.
        i_dec_jal = 1'b1; i_dec_imm = 32'h18;
        step(); check_bubble("jal", 32'h28);
        i_dec_jal = 1'b0;
        step(); check_word("jal.tgt", 32'h28);

        // jalr while held: ignored.
        i_dec_jalr = 1'b1; i_dec_jalr_rs1 = 32'h101; i_dec_imm = 32'h4; i_hold = 1'b1;
        step();
        check("jalrh.pcq", o_imem_raddr, 32'h2C);
        check_word("jalrh", 32'h28);
        // jalr released: (0x101+4)&~1 = 0x104.
        i_hold = 1'b0;
        step(); check_bubble("jalr", 32'h104);
        i_dec_jalr = 1'b0;
        step(); check_word("jalr.tgt", 32'h104);
        check("jalr.mis", {31'd0, o_misalign}, 32'd0);

        // Execute redirect beats hold and jal.
        i_ex_redirect = 1'b1; i_ex_target = 32'h200; i_hold = 1'b1;
        i_dec_jal = 1'b1; i_dec_imm = 32'h40;
        #1 check("ex.flush", {31'd0, o_flush}, 32'd1);
        step(); check_bubble("ex", 32'h200);
        i_ex_redirect = 1'b0; i_hold = 1'b0; i_dec_jal = 1'b0;
        #1 check("ex.noflush", {31'd0, o_flush}, 32'd0);
        step(); check_word("ex.tgt", 32'h200);

        // jal to 0x32 (wraps: 0x200 + 0xFFFFFE32) -> misaligned target.
        i_dec_jal = 1'b1; i_dec_imm = 32'hFFFF_FE32;
        step(); check_bubble("jalmis", 32'h32);
        check("jalmis.mis0", {31'd0, o_misalign}, 32'd0);
        i_dec_jal = 1'b0;
        step(); check_word("mis.tgt", 32'h32);
        check("mis.set", {31'd0, o_misalign}, 32'd1);
        step(); check_word("mis.next", 32'h36);
        check("mis.clr", {31'd0, o_misalign}, 32'd0);

        // Halt: sticky freeze after the pulse drops.
        i_halt = 1'b1;
        step(); check_bubble("halt", 32'h3A);
        i_halt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(); check_bubble("halted", 32'h3A);
        end

        // Async reset mid-cycle restores RESET_ADDR.
        #2 i_rst = 1'b1;
        #1;
        check("arst.pcq", o_imem_raddr, 32'h0);
        check("arst.pc",  o_pc, 32'h0);
        check("arst.npc", o_nxt_pc, 32'h4);
        check("arst.vld", {31'd0, o_vld}, 32'd0);
        #1 i_rst = 1'b0;
        step(); check_word("arst.run", 32'h0);

        // jalr over jal when both asserted: (0x11+8)&~1 = 0x18, not 0+8.
        i_dec_jal = 1'b1; i_dec_jalr = 1'b1; i_dec_imm = 32'h8; i_dec_jalr_rs1 = 32'h11;
        step(); check_bubble("both", 32'h18);
        i_dec_jal = 1'b0; i_dec_jalr = 1'b0;
        step(); check_word("both.tgt", 32'h18);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
